gfx_rom_arb: RTL and testbench
==============================

GFX_ROM_ARB -- requirements
Module: gfx_rom_arb

Interface
REQ-001 SHALL have parameter AW, default 16, meaning requester and memory address width.
REQ-002 SHALL have parameter DW, default 16, meaning ROM data width.
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic rises on clk_sys.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rqN_req  input  1  fetch request from requester N, N=0 char, 1 bg, 2 sprite; level, held until ack.
REQ-006 SHALL have ports rqN_addr  input  AW  ROM address; stable while rqN_req is high.
REQ-007 SHALL have ports rqN_ack  output  1  one-cycle pulse; rqN_data valid in that cycle.
REQ-008 SHALL have ports rqN_data  output  DW  last data fetched for requester N; held until the next ack to N.
REQ-009 SHALL have port mem_rd  output  1  one-cycle read strobe to the shared ROM.
REQ-010 SHALL have port mem_addr  output  AW  ROM address; held from mem_rd until mem_ready.
REQ-011 SHALL have port mem_ready  input  1  one-cycle pulse; mem_data valid in that cycle.
REQ-012 SHALL have port mem_data  input  DW  ROM read data.
REQ-013 SHALL have port dl  input  1  ROM download in progress (driven by ioctl_download).
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, WAIT, ACK.
REQ-016 IDLE: when dl low and any eligible request exists, SHALL select one winner by round-robin, search starting at (last_grant+1) mod 3, wrapping 2->0.
REQ-017 Eligible = rqN_req high and N not acked in the previous cycle (one-cycle mask after each ack).
REQ-018 Hit: if winner valid[N]=1 and rqN_addr==tag[N], SHALL go to ACK next cycle with no mem_rd; ack latency 2 cycles from req sample.
REQ-019 Miss: SHALL load mem_addr=rqN_addr and go to ISSUE; ISSUE drives mem_rd=1 for exactly one cycle, then WAIT.
REQ-020 WAIT: SHALL hold mem_addr; on mem_ready SHALL capture mem_data into rqN_data, set tag[N]=addr, valid[N]=1, go to ACK.
REQ-021 ACK: SHALL pulse rqN_ack for exactly one cycle for the granted N only, set last_grant=N, return to IDLE.
REQ-022 mem_ready outside WAIT SHALL be ignored.
REQ-023 At most one request SHALL be in flight; only one rqN_ack may be high in any cycle.
REQ-024 Round-robin SHALL update last_grant on hits and misses alike; with all three requesting continuously, grant order SHALL be 0,1,2,0,...
REQ-025 dl high SHALL block new grants in IDLE; an ISSUE/WAIT in progress SHALL complete and ack normally.
REQ-026 dl high SHALL clear valid[0..2] every cycle, so the first fetch after dl falls is always a miss.
REQ-027 A request whose address changes while acked data is held SHALL miss and refetch.

Reset
REQ-028 reset low SHALL asynchronously force state IDLE, mem_rd=0, mem_addr=0, all rqN_ack=0, all rqN_data=0, valid=0, tags=0, last_grant=2, busy=0.
REQ-029 Reset asserted mid-WAIT SHALL abandon the fetch; a mem_ready arriving after reset release while in IDLE SHALL be ignored.
REQ-030 After reset release the first grant SHALL go to requester 0 when it is requesting.

Verification
REQ-031 rq1_req=1, addr=0x1234, mem_ready 3 cycles after mem_rd, mem_data=0xBEEF -> one mem_rd with mem_addr=0x1234, rq1_ack pulse one cycle after mem_ready, rq1_data=0xBEEF.
REQ-032 rq1 re-requests 0x1234 -> rq1_ack 2 cycles later, no mem_rd, data 0xBEEF; then addr 0x1235 -> miss, mem_rd issued.
REQ-033 All three requests held high, memory latency 1 -> acks in order 0,1,2,0; no overlapping acks; mem_rd never issued while busy in WAIT.
REQ-034 dl raised during WAIT -> pending fetch acks normally; no further mem_rd while dl=1; after dl falls, request to previously cached address issues mem_rd.
REQ-035 reset pulsed low during WAIT, then mem_ready pulse -> no ack, all outputs at reset values, next rq0 request fetched normally.
REQ-036 Spurious mem_ready in IDLE with no requests -> no ack, no state change, busy stays 0.

Source files
------------

// File: rtl/gfx_rom_arb.sv
// Three-way round-robin arbiter in front of a shared graphics ROM.
// Each requester has a one-entry tag/data cache, so a repeated fetch of the same address is acked without a ROM read.
module gfx_rom_arb #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          rq0_req,
  input  logic [AW-1:0] rq0_addr,
  output logic          rq0_ack,
  output logic [DW-1:0] rq0_data,
  input  logic          rq1_req,
  input  logic [AW-1:0] rq1_addr,
  output logic          rq1_ack,
  output logic [DW-1:0] rq1_data,
  input  logic          rq2_req,
  input  logic [AW-1:0] rq2_addr,
  output logic          rq2_ack,
  output logic [DW-1:0] rq2_data,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_data,
  input  logic          dl,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // Handshake: a requester holds rqN_req high with a stable rqN_addr until it
  // sees the one-cycle rqN_ack; rqN_data is valid in that cycle and held after.
  // Towards the ROM, mem_rd is a one-cycle strobe and mem_addr stays put until
  // the one-cycle mem_ready; mem_ready outside WAIT is ignored.

  logic [1:0]    state;
  logic [1:0]    grant;
  logic [1:0]    last_grant;
  logic [1:0]    start;
  logic [1:0]    win;
  logic [2:0]    sum;
  logic          found;
  logic          hit;
  logic [2:0]    req_v;
  logic [2:0]    elig;
  logic [2:0]    ack_v;
  logic [2:0]    ack_prev;
  logic [2:0]    valid;
  logic [AW-1:0] req_addr [3];
  logic [AW-1:0] tag [3];
  logic [DW-1:0] rdata [3];

  assign req_v       = {rq2_req, rq1_req, rq0_req};
  assign req_addr[0] = rq0_addr;
  assign req_addr[1] = rq1_addr;
  assign req_addr[2] = rq2_addr;

  // A requester acked last cycle is still showing its old request level; skip it once.
  assign elig  = req_v & ~ack_prev;
  assign start = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    sum   = 3'd0;
    for (int i = 0; i < 3; i++) begin
      sum = {1'b0, start} + 3'(i);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!found && elig[sum[1:0]]) begin
        found = 1'b1;
        win   = sum[1:0];
      end
    end
  end

  assign hit   = valid[win] && (req_addr[win] == tag[win]);
  assign ack_v = (state == S_ACK) ? (3'b001 << grant) : 3'b000;

  assign rq0_ack   = ack_v[0];
  assign rq1_ack   = ack_v[1];
  assign rq2_ack   = ack_v[2];
  assign rq0_data  = rdata[0];
  assign rq1_data  = rdata[1];
  assign rq2_data  = rdata[2];
  assign mem_rd    = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd2;
      mem_addr   <= '0;
      valid      <= '0;
      ack_prev   <= '0;
      for (int i = 0; i < 3; i++) begin
        tag[i]   <= '0;
        rdata[i] <= '0;
      end
    end else begin
      ack_prev <= ack_v;
      case (state)
        S_IDLE: begin
          if (!dl && found) begin
            grant <= win;
            if (hit) begin
              state <= S_ACK;
            end else begin
              mem_addr <= req_addr[win];
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mem_ready) begin
            rdata[grant] <= mem_data;
            tag[grant]   <= mem_addr;
            valid[grant] <= 1'b1;
            state        <= S_ACK;
          end
        end
        S_ACK: begin
          last_grant <= grant;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A download rewrites the ROM, so every cached word is stale; this wins over a fill.
      if (dl) valid <= '0;
    end
  end

endmodule

// File: tb/tb_gfx_rom_arb.sv
// Bench for gfx_rom_arb: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_gfx_rom_arb;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    req = '0;
  logic [AW-1:0] addr [3] = '{default: '0};
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          dl = 1'b0;
  logic          rq0_ack, rq1_ack, rq2_ack;
  logic [DW-1:0] rq0_data, rq1_data, rq2_data;
  logic          mem_rd, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    st;
  logic [2:0]    ack;
  logic [DW-1:0] dout [3];

  assign ack     = {rq2_ack, rq1_ack, rq0_ack};
  assign dout[0] = rq0_data;
  assign dout[1] = rq1_data;
  assign dout[2] = rq2_data;

  gfx_rom_arb #(.AW(AW), .DW(DW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .rq0_req(req[0]), .rq0_addr(addr[0]), .rq0_ack(rq0_ack), .rq0_data(rq0_data),
    .rq1_req(req[1]), .rq1_addr(addr[1]), .rq1_ack(rq1_ack), .rq1_data(rq1_data),
    .rq2_req(req[2]), .rq2_addr(addr[2]), .rq2_ack(rq2_ack), .rq2_data(rq2_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .dl(dl), .busy(busy), .state_dbg(st)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int ack_log[$];
  logic [2:0] ack_last = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ROM responder
  logic       auto_mem = 1'b1;
  logic       rnd = 1'b0;
  int         lat = 3;
  int         spur_req = 0;
  int         spur_done = 0;

  initial begin
    logic [AW-1:0] a;
    int l;
    forever begin
      @(posedge clk_sys); #1;
      mem_ready = 1'b0;
      if (spur_req != spur_done) begin
        spur_done = spur_req;
        mem_ready = 1'b1;
        mem_data  = 16'h5A5A;
      end else if (auto_mem && mem_rd) begin
        a = mem_addr;
        l = rnd ? $urandom_range(1, 4) : lat;
        repeat (l) @(posedge clk_sys);
        #1;
        mem_ready = 1'b1;
        mem_data  = a ^ 16'hACDB;
      end else if (rnd && $urandom_range(0, 99) < 3) begin
        mem_ready = 1'b1;
        mem_data  = 16'($urandom);
      end
    end
  end

  // Transaction-level model: one fetch at a time, identified by requester and its age
  // in cycles since the grant; -1 means nothing outstanding.
  int            m_last = 2;
  int            m_n = 0;
  int            m_age = -1;
  int            m_ack_n = -1;
  int            m_mask = -1;
  int            m_nxt;
  int            m_pick;
  logic [AW-1:0] m_addr = '0;
  logic          m_valid [3] = '{default: 1'b0};
  logic [AW-1:0] m_tag [3] = '{default: '0};
  logic [DW-1:0] m_data [3] = '{default: '0};

  always @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      m_last = 2; m_n = 0; m_age = -1; m_ack_n = -1; m_mask = -1; m_addr = '0;
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
      end
    end else begin
      m_nxt = -1;
      if (m_ack_n >= 0) begin
        m_last = m_ack_n;
      end else if (m_age >= 0) begin
        if (m_age >= 2 && mem_ready) begin
          m_data[m_n]  = mem_data;
          m_tag[m_n]   = m_addr;
          m_valid[m_n] = 1'b1;
          m_nxt        = m_n;
          m_age        = -1;
        end else begin
          m_age++;
        end
      end else if (!dl) begin
        m_pick = -1;
        for (int k = 1; k <= 3; k++)
          if (m_pick < 0 && req[(m_last + k) % 3] && ((m_last + k) % 3) != m_mask)
            m_pick = (m_last + k) % 3;
        if (m_pick >= 0) begin
          m_n = m_pick;
          if (m_valid[m_pick] && addr[m_pick] == m_tag[m_pick]) begin
            m_nxt = m_pick;
          end else begin
            m_addr = addr[m_pick];
            m_age  = 1;
          end
        end
      end
      m_mask  = m_ack_n;
      m_ack_n = m_nxt;
      if (dl) for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clk_sys) begin
    logic [2:0] e_ack;
    ack_last = ack;
    if (mem_rd) rd_cnt++;
    for (int i = 0; i < 3; i++) if (ack[i]) ack_log.push_back(i);
    if (reset) begin
      e_ack = (m_ack_n >= 0) ? 3'(1 << m_ack_n) : 3'b000;
      chk("ack_vec", 32'(ack), 32'(e_ack));
      chk("mem_rd", 32'(mem_rd), 32'(m_age == 1));
      chk("busy", 32'(busy), 32'((m_age >= 0) || (m_ack_n >= 0)));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      for (int i = 0; i < 3; i++) chk($sformatf("data%0d", i), 32'(dout[i]), 32'(m_data[i]));
    end
  end

  // driver tasks
  task automatic drive_req(input int n, input logic [AW-1:0] a);
    @(posedge clk_sys); #1;
    req[n]  = 1'b1;
    addr[n] = a;
  endtask

  task automatic drop(input int n);
    @(posedge clk_sys); #1;
    req[n] = 1'b0;
  endtask

  task automatic wait_ack(input int n, output int cyc);
    cyc = 0;
    @(negedge clk_sys);
    while (!ack[n] && cyc < 40) begin
      cyc++;
      @(negedge clk_sys);
    end
    chk($sformatf("ack%0d_seen", n), 32'(ack[n]), 32'd1);
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 10 && !mem_rd; i++) @(negedge clk_sys);
    chk("rd_seen", 32'(mem_rd), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 16'h0010;
      1: return 16'h0011;
      2: return 16'h0020;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int cyc, r0, a0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data1", 32'(rq1_data), 32'd0);

    // single miss then hit, then address change
    lat = 3;
    drive_req(1, 16'h1234);
    r0 = rd_cnt;
    wait_ack(1, cyc);
    chk("miss_lat", 32'(cyc), 32'd5);
    chk("miss_data", 32'(rq1_data), 32'hBEEF);
    chk("miss_rd_cnt", 32'(rd_cnt - r0), 32'd1);
    chk("miss_addr", 32'(mem_addr), 32'h1234);
    drop(1);
    drive_req(1, 16'h1234);
    r0 = rd_cnt;
    wait_ack(1, cyc);
    chk("hit_lat", 32'(cyc), 32'd1);
    chk("hit_data", 32'(rq1_data), 32'hBEEF);
    chk("hit_rd_cnt", 32'(rd_cnt - r0), 32'd0);
    drop(1);
    drive_req(1, 16'h1235);
    r0 = rd_cnt;
    wait_ack(1, cyc);
    chk("chg_lat", 32'(cyc), 32'd5);
    chk("chg_data", 32'(rq1_data), 32'hBEEE);
    chk("chg_rd_cnt", 32'(rd_cnt - r0), 32'd1);
    drop(1);

    // all three held high: round-robin order from reset
    pulse_reset();
    lat = 1;
    a0 = ack_log.size();
    @(posedge clk_sys); #1;
    addr[0] = 16'h0040; addr[1] = 16'h0050; addr[2] = 16'h0060;
    req = 3'b111;
    for (int i = 0; i < 60 && ack_log.size() < a0 + 4; i++) begin
      @(negedge clk_sys); #1;
    end
    @(posedge clk_sys); #1;
    req = 3'b000;
    chk("rr_count", 32'(ack_log.size() >= a0 + 4), 32'd1);
    if (ack_log.size() >= a0 + 4) begin
      chk("rr_0", 32'(ack_log[a0]), 32'd0);
      chk("rr_1", 32'(ack_log[a0 + 1]), 32'd1);
      chk("rr_2", 32'(ack_log[a0 + 2]), 32'd2);
      chk("rr_3", 32'(ack_log[a0 + 3]), 32'd0);
    end
    repeat (4) @(posedge clk_sys);

    // download raised during a fetch
    lat = 4;
    drive_req(0, 16'h0070);
    wait_ack(0, cyc);
    drop(0);
    drive_req(2, 16'h0080);
    wait_rd();
    @(posedge clk_sys); #1;
    dl = 1'b1;
    wait_ack(2, cyc);
    chk("dl_pend_data", 32'(rq2_data), 32'hAC5B);
    drop(2);
    r0 = rd_cnt;
    drive_req(0, 16'h0070);
    repeat (10) @(negedge clk_sys);
    chk("dl_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("dl_no_ack", 32'(ack), 32'd0);
    chk("dl_idle", 32'(busy), 32'd0);
    @(posedge clk_sys); #1;
    dl = 1'b0;
    wait_ack(0, cyc);
    chk("post_dl_lat", 32'(cyc), 32'd6);
    chk("post_dl_rd", 32'(rd_cnt - r0), 32'd1);
    chk("post_dl_data", 32'(rq0_data), 32'hACAB);
    drop(0);

    // reset in the middle of WAIT, then a stray mem_ready
    auto_mem = 1'b0;
    drive_req(0, 16'h0090);
    wait_rd();
    @(posedge clk_sys); #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_d0", 32'(rq0_data), 32'd0);
    chk("mid_rst_d2", 32'(rq2_data), 32'd0);
    req[0] = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    spur_req++;
    repeat (4) begin
      @(negedge clk_sys);
      chk("spur_ack", 32'(ack), 32'd0);
      chk("spur_busy", 32'(busy), 32'd0);
    end
    auto_mem = 1'b1;
    lat = 2;
    drive_req(0, 16'h0090);
    r0 = rd_cnt;
    wait_ack(0, cyc);
    chk("refetch_lat", 32'(cyc), 32'd4);
    chk("refetch_rd", 32'(rd_cnt - r0), 32'd1);
    chk("refetch_data", 32'(rq0_data), 32'hAC4B);
    drop(0);
    repeat (3) @(posedge clk_sys);

    // random traffic
    rnd = 1'b1;
    repeat (2000) begin
      @(posedge clk_sys); #1;
      for (int n = 0; n < 3; n++) begin
        if (req[n]) begin
          if (ack_last[n]) begin
            if ($urandom_range(0, 1) == 1) req[n] = 1'b0;
            else addr[n] = pick_addr();
          end
        end else if ($urandom_range(0, 99) < 30) begin
          req[n]  = 1'b1;
          addr[n] = pick_addr();
        end
      end
      if (dl) dl = ($urandom_range(0, 99) >= 20);
      else dl = ($urandom_range(0, 99) < 2);
    end
    rnd = 1'b0;
    req = 3'b000;
    dl  = 1'b0;
    repeat (20) @(posedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
